// File: rtl/a1csa_seq64.sv
// a1csa_seq64 -- multi-cycle add-one carry-select adder.
//
// Operands are accepted through a valid/ready handshake and resolved one
// W-bit slice per clock, least significant slice first. Each slice forms
// the zero-carry sum, the add-one sum and the slice generate/propagate. The
// running carry selects between the two sums. Slice gen/prop are folded
// serially into a group generate/propagate pair, so this block consumes the
// same group gen/prop interface the hierarchical a1csah adders produce.
//
// Optional feature: define A1CSA_SEQ_SUB_EN to add the 'sub' input.
// With sub=1, b is inverted at capture and the carry-in is forced to 1, so
// the result is a - b. In that mode cout=1 means no borrow, and gen/prop
// describe a + ~b.
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst        synchronous, active-high reset
//   in_valid   operands present
//   in_ready   block can accept operands (IDLE only)
//   cin        carry in
//   a, b       N-bit operands
//   sub        (A1CSA_SEQ_SUB_EN only) subtract select, captured with a/b
//   out_valid  result present (DONE only)
//   out_ready  consumer accepts result
//   s          sum, a + b + cin mod 2^N
//   cout       carry out of bit N-1
//   gen        group generate: carry out of a + b with cin=0
//   prop       group propagate: every bit of a ^ b is 1
module a1csa_seq64 #(
  parameter int N = 64,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         cin,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
`ifdef A1CSA_SEQ_SUB_EN
  input  logic         sub,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         gen,
  output logic         prop
);

  localparam int NS = N / W;
  localparam int KW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic [KW-1:0]  k;

  // Captured operands; shifted right one slice per RUN cycle so the
  // current slice always sits in the low W bits.
  logic [N-1:0]   a_r, b_r;
  logic           carry, g_acc, p_acc;

  logic [N-1:0]   s_r;
  logic           cout_r, gen_r, prop_r;

  logic [N-1:0]   b_cap;
  logic           cin_cap;

  logic [W-1:0]   a_k, b_k, sum1, s_k;
  logic [W:0]     sum0;
  logic           g_k, p_k, carry_nxt, g_nxt, p_nxt, last;
  logic [N-1:0]   s_shift;

`ifdef A1CSA_SEQ_SUB_EN
  assign b_cap   = sub ? ~b : b;
  assign cin_cap = sub | cin;
`else
  assign b_cap   = b;
  assign cin_cap = cin;
`endif

  assign last = (k == KW'(NS - 1));

  // Slice datapath: both candidate sums, slice gen/prop, carry select and
  // the serial group gen/prop fold.
  always_comb begin
    a_k       = a_r[W-1:0];
    b_k       = b_r[W-1:0];
    sum0      = {1'b0, a_k} + {1'b0, b_k};
    // Only the low W bits of the add-one sum are ever selected; the carry
    // out of the slice comes from g_k/p_k instead.
    sum1      = a_k + b_k + {{(W-1){1'b0}}, 1'b1};
    g_k       = sum0[W];
    p_k       = &(a_k ^ b_k);
    s_k       = carry ? sum1 : sum0[W-1:0];
    carry_nxt = g_k | (p_k & carry);
    g_nxt     = g_k | (p_k & g_acc);
    p_nxt     = p_acc & p_k;
    // Result fills from the top so after NS slices slice 0 lands in [W-1:0].
    s_shift          = s_r >> W;
    s_shift[N-1 -: W] = s_k;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Control and result registers: these carry defined reset values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      k      <= '0;
      s_r    <= '0;
      cout_r <= 1'b0;
      gen_r  <= 1'b0;
      prop_r <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (in_valid) k <= '0;
        RUN: begin
          s_r <= s_shift;
          if (last) begin
            k      <= '0;
            cout_r <= carry_nxt;
            gen_r  <= g_nxt;
            prop_r <= p_nxt;
          end else begin
            k <= k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Working operand/carry registers: only meaningful in RUN, so no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      if (in_valid) begin
        a_r   <= a;
        b_r   <= b_cap;
        carry <= cin_cap;
        g_acc <= 1'b0;
        p_acc <= 1'b1;
      end
    end else if (state == RUN) begin
      a_r   <= a_r >> W;
      b_r   <= b_r >> W;
      carry <= carry_nxt;
      g_acc <= g_nxt;
      p_acc <= p_nxt;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign s         = s_r;
  assign cout      = cout_r;
  assign gen       = gen_r;
  assign prop      = prop_r;

endmodule

// File: tb/tb_a1csa_seq64.sv
// Testbench for a1csa_seq64: directed cases plus randomized handshaking,
// with a queue of expected results checked by an independent monitor.
module tb_a1csa_seq64;
  localparam int N  = 64;
  localparam int W  = 16;
  localparam int NS = N / W;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, cin, out_valid, out_ready;
  logic         cout, gen, prop;
  logic [N-1:0] a, b, s;
`ifdef A1CSA_SEQ_SUB_EN
  logic         sub;
`endif

  always #5 clk = ~clk;

  a1csa_seq64 #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .cin(cin), .a(a), .b(b),
`ifdef A1CSA_SEQ_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .gen(gen), .prop(prop)
  );

  typedef struct packed {
    logic [N-1:0] s;
    logic         cout;
    logic         gen;
    logic         prop;
  } res_t;

  res_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_acc = 0;
  int   n_out = 0;
  int   ready_mode = 1;   // 0: hold low, 1: hold high, 2: random

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: whole-word arithmetic on 65-bit values.
  function automatic res_t model(input logic [N-1:0] aa, input logic [N-1:0] bb,
                                 input logic ci, input logic sb);
    logic [N:0] t, t0;
    res_t r;
    if (sb) begin
      bb = ~bb;
      ci = 1'b1;
    end
    t0     = {1'b0, aa} + {1'b0, bb};
    t      = t0 + {{N{1'b0}}, ci};
    r.s    = t[N-1:0];
    r.cout = t[N];
    r.gen  = t0[N];
    r.prop = (t0 == {1'b0, {N{1'b1}}});
    return r;
  endfunction

  // Monitor: decides out_ready for the coming edge, and when that edge
  // will complete a handshake, compares the presented result.
  initial begin
    res_t e;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_output: got s=%0h with no transaction pending", s);
        end else begin
          e = q.pop_front();
          n_out++;
          check("sum", s, e.s);
          check("cout", {63'b0, cout}, {63'b0, e.cout});
          check("gen", {63'b0, gen}, {63'b0, e.gen});
          check("prop", {63'b0, prop}, {63'b0, e.prop});
        end
      end
    end
  end

  task automatic set_sub(input logic sb);
`ifdef A1CSA_SEQ_SUB_EN
    sub = sb;
`else
    if (sb) $display("note: sub requested in an add-only build");
`endif
  endtask

  // One directed transaction; optionally holds out_ready low for 10 cycles.
  task automatic run_one(input logic [N-1:0] aa, input logic [N-1:0] bb,
                         input logic ci, input logic sb, input bit hold);
    int   cnt;
    res_t ex;
    @(negedge clk);
    a = aa; b = bb; cin = ci; set_sub(sb); in_valid = 1'b1;
    cnt = 0;
    while (!in_ready && cnt < 100) begin @(negedge clk); cnt++; end
    check("accept_timeout", {63'b0, in_ready}, 64'd1);
    ex = model(aa, bb, ci, sb);
    if (hold) ready_mode = 0;
    q.push_back(ex);
    n_acc++;
    @(negedge clk);
    in_valid = 1'b1;   // ignored while busy
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin = ~ci;
    check("in_ready_in_run", {63'b0, in_ready}, 64'd0);
    in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 50) begin @(negedge clk); cnt++; end
    check("latency", cnt, NS);
    if (hold) begin
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        check("hold_valid", {63'b0, out_valid}, 64'd1);
        check("hold_in_ready", {63'b0, in_ready}, 64'd0);
        check("hold_s", s, ex.s);
        check("hold_cout", {63'b0, cout}, {63'b0, ex.cout});
      end
      ready_mode = 1;
    end
    cnt = 0;
    while (!in_ready && cnt < 50) begin @(negedge clk); cnt++; end
    check("return_idle", {63'b0, in_ready}, 64'd1);
  endtask

  initial begin
    int cyc, n_rand;
    logic sb;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; set_sub(1'b0);
    repeat (3) @(negedge clk);
    check("rst_in_ready", {63'b0, in_ready}, 64'd1);
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_s", s, 64'd0);
    check("rst_flags", {61'b0, cout, gen, prop}, 64'd0);
    rst = 1'b0;

    run_one(64'h1, 64'h1, 1'b0, 1'b0, 1'b0);
    run_one(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 1'b0);
    run_one(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1);
    run_one(64'h0000_FFFF_0000_FFFF, 64'hFFFF_0000_FFFF_0000, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of RUN: the partial result must never appear.
    @(negedge clk);
    a = 64'h1234; b = 64'h5678; cin = 1'b0; in_valid = 1'b1;
    check("ready_before_abort", {63'b0, in_ready}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", {63'b0, in_ready}, 64'd1);
    check("abort_out_valid", {63'b0, out_valid}, 64'd0);
    check("abort_s", s, 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_output", {63'b0, out_valid}, 64'd0);
    end
    run_one(64'd3, 64'd4, 1'b0, 1'b0, 1'b0);

`ifdef A1CSA_SEQ_SUB_EN
    run_one(64'd5, 64'd7, 1'b0, 1'b1, 1'b0);
    run_one(64'd7, 64'd5, 1'b0, 1'b1, 1'b0);
`endif

    // Randomized traffic with random in_valid and out_ready.
    ready_mode = 2;
    cyc = 0;
    n_rand = 0;
    while (n_rand < 200 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      in_valid = ($urandom_range(0, 1) == 1);
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) b = ~a;
      else if ($urandom_range(0, 7) == 0) b = -a;
      cin = $urandom_range(0, 1);
`ifdef A1CSA_SEQ_SUB_EN
      sb = $urandom_range(0, 1);
`else
      sb = 1'b0;
`endif
      set_sub(sb);
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, cin, sb));
        n_acc++;
        n_rand++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (q.size() != 0 && cyc < 500) begin @(negedge clk); cyc++; end
    check("drain", q.size(), 64'd0);
    check("txn_count", n_out, n_acc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
